// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path.
// State encoding, default sample width and buffer depth.
package la_pkg;

    localparam int LA_DEPTH = 16;
    localparam int LA_SW    = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Kept free of reset so it can be swapped for a hard RAM macro.
module capture_ram
    import la_pkg::*;
#(
    parameter int DEPTH = LA_DEPTH,
    parameter int AW    = 4,
    parameter int SW    = LA_SW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [SW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [SW-1:0] rdata
);

    logic [SW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_buffer.sv
// Trigger-qualified circular sample recorder with oldest-first readout.
// Freezes PRE samples before the trigger and DEPTH-1-PRE after it.
module capture_buffer
    import la_pkg::*;
#(
    parameter int DEPTH = LA_DEPTH,
    parameter int AW    = 4,
    parameter int SW    = LA_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          abort,
    input  logic          sample_en,
    input  logic [SW-1:0] in_data,
    input  logic          trigger,
    input  logic [AW-1:0] pre_count,
    input  logic          rd_en,
    output logic          busy,
    output logic          triggered,
    output logic          done,
    output logic [SW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_last,
    output logic [2:0]    state
);

    localparam logic [AW:0] RD_ALL = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] p_q, p_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] post_q, post_d;
    logic [AW-1:0] trig_ptr_q, trig_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic          trig_q, trig_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          ram_we, ram_re;
    logic [AW-1:0] post_load;
    logic [SW-1:0] ram_rdata;

    assign post_load = AW'(DEPTH - 1) - p_q;

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        post_d     = post_q;
        trig_ptr_d = trig_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        trig_d     = trig_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
        end else if (arm && !abort &&
                     (state_q == ST_IDLE || state_q == ST_DONE)) begin
            p_d      = pre_count;
            wr_ptr_d = '0;
            cnt_d    = '0;
            trig_d   = 1'b0;
            state_d  = (pre_count == '0) ? ST_WAIT : ST_PRE;
        end else begin
            unique case (state_q)
                ST_PRE: begin
                    if (sample_en) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = cnt_q + AW'(1);
                        if (cnt_q + AW'(1) == p_q) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sample_en) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (trigger) begin
                            trig_ptr_d = wr_ptr_q;
                            trig_d     = 1'b1;
                            post_d     = post_load;
                            if (post_load == '0) begin
                                state_d  = ST_DONE;
                                rd_ptr_d = wr_ptr_q - p_q;
                                rd_cnt_d = '0;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        post_d   = post_q - AW'(1);
                        if (post_q == AW'(1)) begin
                            state_d  = ST_DONE;
                            rd_ptr_d = trig_ptr_q - p_q;
                            rd_cnt_d = '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_en && rd_cnt_q != RD_ALL) begin
                        ram_re     = 1'b1;
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        rd_cnt_d   = rd_cnt_q + (AW+1)'(1);
                        rd_valid_d = 1'b1;
                        rd_last_d  = (rd_cnt_q == RD_ALL - (AW+1)'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            p_q        <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            post_q     <= '0;
            trig_ptr_q <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            post_q     <= post_d;
            trig_ptr_q <= trig_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .SW    (SW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // RAM output is unreset; gate it so rd_data reads 0 outside a valid beat.
    assign rd_data   = rd_valid_q ? ram_rdata : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign triggered = trig_q;
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q == ST_PRE) || (state_q == ST_WAIT) ||
                       (state_q == ST_POST);
    assign state     = state_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: a sample-list model predicts the
// frozen window and phase; a monitor checks every readout beat.
module tb_capture_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          sample_en = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic          trigger = 1'b0;
    logic [AW-1:0] pre_count = '0;
    logic          rd_en = 1'b0;
    logic          busy, triggered, done, rd_valid, rd_last;
    logic [SW-1:0] rd_data;
    logic [2:0]    state;

    capture_buffer #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .abort     (abort),
        .sample_en (sample_en),
        .in_data   (in_data),
        .trigger   (trigger),
        .pre_count (pre_count),
        .rd_en     (rd_en),
        .busy      (busy),
        .triggered (triggered),
        .done      (done),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] d;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rd_valid: got data %h last %b, want no beat",
                         rd_data, rd_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (rd_data !== mon_e.d || rd_last !== mon_e.l) begin
                    n_bad++;
                    $display("FAIL readout: got %h/%b want %h/%b",
                             rd_data, rd_last, mon_e.d, mon_e.l);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Phase implied by how many samples were taken and where the trigger hit.
    function automatic int mstate(int n, int p, int ti);
        if (n < p) return 1;
        if (ti < 0) return 2;
        if (n < ti + DEPTH - p) return 3;
        return 4;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_trig"}, triggered, 0);
    endtask

    // p: pre count; incr: ramp data; tv1/tv2: trigger values (-1 none);
    // period: 0 random sample_en, else every Nth cycle; abort_post: post
    // count at which to abort (-1 never).
    task automatic capture(input int p, input bit incr, input int tv1,
                           input int tv2, input int period,
                           input int abort_post);
        logic [SW-1:0] samples[$];
        logic [SW-1:0] nxt;
        logic [SW-1:0] dat;
        int  ti;
        int  cyc;
        int  ms;
        bit  se;
        bit  tr;
        ti  = -1;
        cyc = 0;
        nxt = '0;
        arm       = 1'b1;
        pre_count = AW'(p);
        sample_en = 1'b0;
        trigger   = 1'($urandom);
        rd_en     = 1'($urandom);
        tick();
        arm   = 1'b0;
        rd_en = 1'b0;
        while (cyc < 3000) begin
            ms = mstate(samples.size(), p, ti);
            chk("state", state, ms);
            chk("triggered", triggered, ti >= 0);
            chk("done", done, ms == 4);
            chk("busy", busy, ms != 4);
            if (ms == 4) break;
            if (abort_post >= 0 && ms == 3 &&
                (ti + DEPTH - p - samples.size()) == abort_post) begin
                abort     = 1'b1;
                sample_en = 1'($urandom);
                tick();
                abort     = 1'b0;
                sample_en = 1'b0;
                chk_idle("abort");
                rd_en = 1'b1;
                tick();
                tick();
                rd_en = 1'b0;
                tick();
                return;
            end
            se  = (period == 0) ? ($urandom % 10 < 7) : (cyc % period == 0);
            dat = (incr && se) ? nxt : SW'($urandom);
            if (!se) tr = 1'($urandom);
            else if (tv1 >= 0) tr = (int'(dat) == tv1) || (int'(dat) == tv2);
            else tr = ($urandom % 8 == 0) || (samples.size() > p + 40);
            sample_en = se;
            in_data   = dat;
            trigger   = tr;
            if (se) begin
                samples.push_back(dat);
                nxt++;
                if (ti < 0 && samples.size() - 1 >= p && tr)
                    ti = samples.size() - 1;
            end
            tick();
            cyc++;
        end
        sample_en = 1'b0;
        trigger   = 1'b0;
        chk("capture_timeout", cyc < 3000, 1);
        if (cyc >= 3000) return;
        for (int k = 0; k < DEPTH + 2;) begin
            if ($urandom % 3 != 0) begin
                rd_en = 1'b1;
                if (k < DEPTH)
                    exp_q.push_back('{samples[ti - p + k], k == DEPTH - 1});
                k++;
            end else begin
                rd_en = 1'b0;
            end
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
        chk("drain", exp_q.size(), 0);
        chk("done_hold", done, 1);
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        chk_idle("reset");
        chk("reset_rdv", rd_valid, 0);
        chk("reset_rdd", rd_data, 0);

        capture(4, 1, 8'h20, -1, 1, -1);
        capture(4, 1, 8'h01, 8'h09, 1, -1);
        capture(0, 1, 8'h05, -1, 3, -1);
        capture(15, 1, 8'h30, -1, 1, -1);
        capture(4, 1, 8'h20, -1, 1, 6);
        capture(2, 0, -1, -1, 0, -1);

        // Sync reset mid-WAIT, preceded by a glitch between edges.
        arm       = 1'b1;
        pre_count = '0;
        tick();
        arm = 1'b0;
        chk("wait_state", state, 2);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("glitch_state", state, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("sreset");
        chk("sreset_rdv", rd_valid, 0);
        chk("sreset_last", rd_last, 0);
        chk("sreset_rdd", rd_data, 0);

        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk_idle("armabort_idle");

        for (int i = 0; i < 6; i++) begin
            capture(int'($urandom_range(0, DEPTH - 1)), 1'($urandom), -1, -1, 0, -1);
            if (i == 3) begin
                arm   = 1'b1;
                abort = 1'b1;
                tick();
                arm   = 1'b0;
                abort = 1'b0;
                chk_idle("armabort_done");
            end
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
